n_mem_arbiter: RTL
==================

Name: n_mem_arbiter

Overview:
- Shares the single-port, read-only modulus (N) word memory between two requesters.
- Requester 0 is the Montgomery multiplier word fetch; requester 1 is the final compare/subtract stage.
- Each requester asks for a burst of consecutive words. The block round-robin arbitrates, drives the memory address, and tracks the memory's 2-cycle read latency. Returned words are tagged so each requester gets only its own data, with a last-word marker.

Parameters:
- ADDR_WIDTH, 7, word address width of the N memory (128 x 32-bit words = 4096 bits).
- DATA_WIDTH, 32, memory word width.
- RD_LAT, 2, cycles from address-drive cycle to mem_q valid (address register + output register); fixed at 2 for this memory.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  burst request per requester, bit i = requester i; held high with stable start/len until gnt[i].
- start_addr0  in  ADDR_WIDTH  first word address, requester 0.
- len0  in  ADDR_WIDTH+1  word count, requester 0 (0..2^ADDR_WIDTH).
- start_addr1  in  ADDR_WIDTH  first word address, requester 1.
- len1  in  ADDR_WIDTH+1  word count, requester 1.
- gnt  out  2  one-cycle grant pulse, coincident with the first address cycle of the burst.
- busy  out  1  high while in BURST state.
- mem_address  out  ADDR_WIDTH  registered address to the N memory.
- mem_q  in  DATA_WIDTH  N memory read data.
- rd_data  out  DATA_WIDTH  mem_q passed through combinationally, shared by both requesters.
- rd_valid  out  2  bit i high when rd_data belongs to requester i.
- rd_last  out  1  high with the final word of a burst.
- done  out  2  one-cycle burst-complete pulse per requester.

Behaviour:
- Reset values (first edge with reset=1): gnt=0, busy=0, mem_address=0, rd_valid=0, rd_last=0, done=0, state=IDLE, last_grant=1 (so requester 0 wins the first tie).
- Reset mid-burst:
  - Aborts the burst and clears the tag pipeline.
  - In-flight reads are never reported.
  - rd_valid=0 from the cycle after the reset edge.
- States: IDLE, BURST.
- IDLE, at each edge:
  - If any req is high, select a winner. If both are high, the winner is the requester not equal to last_grant; otherwise the sole requester wins.
  - Registered effects: gnt[w]=1, mem_address=start_addr_w, remaining=len_w-1, owner=w, last_grant=w, state=BURST.
- BURST, at each edge while remaining>0: mem_address += 1 (modulo 2^ADDR_WIDTH, wraps 127->0), remaining -= 1.
- Final address cycle (remaining==0): arbitration is evaluated at this edge exactly as in IDLE. A pending request starts its burst with zero bubble; otherwise state returns to IDLE.
- The granted requester's req bit must be low by the cycle after gnt. If it is still high, it is treated as a new request.
- Tag pipeline: RD_LAT-deep shift of {valid, owner, last, zero_len}, entered at each address cycle.
  - rd_valid[owner] and rd_last appear exactly RD_LAT cycles after the corresponding address cycle, aligned with mem_q.
  - done[owner] pulses with rd_last.
- len=0:
  - Granted normally, but no memory read is issued and no rd_valid is produced.
  - Occupies one address cycle (mem_address=start, the read is ignored).
  - done pulses RD_LAT cycles after gnt.
  - Then arbitration proceeds as for a final cycle.
- len=2^ADDR_WIDTH: reads every word once, starting at start_addr and wrapping.
- Memory is read-only; no write path exists in this block.
- rd_valid is never high for both bits in one cycle.

Test Plan:
- Reset, then req=01, start0=0x05, len0=3 → gnt=01 in cycle T; mem_address 0x05,0x06,0x07 in T..T+2; rd_valid=01 in T+2..T+4 with data words 5,6,7 of nMem.mif; rd_last and done[0] in T+4; busy falls after T+2.
- req=11 held, len0=len1=2, both start 0x10 → gnt 01 at T, gnt 10 at T+2 (no bubble), gnt 01 again at T+4 if req0 is re-raised; rd_valid strictly alternates in 2-word groups.
- start1=0x7E, len1=4 → addresses 0x7E,0x7F,0x00,0x01; 4 valid words, rd_last on the 4th.
- len0=0 → gnt[0] at T, no rd_valid ever, done[0]=1 at T+2, busy low at T+1 if no other request.
- reset asserted at T+1 of an 8-word burst → from T+2 all outputs 0, no rd_valid/done for the aborted burst; a new req afterwards is served correctly.
- len0=128, start0=0x40 → 128 consecutive valid words covering all addresses once; rd_last only on word at 0x3F.

Source files
------------

// File: rtl/n_mem_arbiter.sv
// Round-robin arbiter sharing the read-only modulus (N) word memory between the
// Montgomery word fetch (requester 0) and the compare/subtract stage (requester 1).
module n_mem_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [ADDR_WIDTH-1:0] start_addr0,
    input  logic [ADDR_WIDTH:0]   len0,
    input  logic [ADDR_WIDTH-1:0] start_addr1,
    input  logic [ADDR_WIDTH:0]   len1,
    output logic [1:0]            gnt,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            rd_valid,
    output logic                  rd_last,
    output logic [1:0]            done
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  zlen_q, zlen_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            gnt_q, gnt_d;

    // Tag pipeline: one entry per address cycle, emerging aligned with mem_q.
    logic                  tag_used_q [RD_LAT];
    logic                  tag_vld_q  [RD_LAT];
    logic                  tag_own_q  [RD_LAT];
    logic                  tag_last_q [RD_LAT];

    logic                  final_cyc;
    logic                  can_arb;
    logic                  win;
    logic [ADDR_WIDTH:0]   len_w;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        zlen_d       = zlen_q;
        remaining_d  = remaining_q;
        addr_d       = addr_q;
        gnt_d        = 2'b00;

        final_cyc = (state_q == BURST) && (remaining_q == '0);
        can_arb   = (state_q == IDLE) || final_cyc;
        // On a tie the requester that did not win last time goes next.
        win       = (&req) ? ~last_grant_q : req[1];
        len_w     = win ? len1 : len0;

        if (can_arb && (|req)) begin
            state_d      = BURST;
            gnt_d        = win ? 2'b10 : 2'b01;
            addr_d       = win ? start_addr1 : start_addr0;
            remaining_d  = (len_w == '0) ? '0 : len_w - REM_ONE;
            zlen_d       = (len_w == '0);
            owner_d      = win;
            last_grant_d = win;
        end else if (state_q == BURST && remaining_q != '0) begin
            addr_d      = addr_q + ADDR_ONE;
            remaining_d = remaining_q - REM_ONE;
        end else if (final_cyc) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            zlen_q       <= 1'b0;
            remaining_q  <= '0;
            addr_q       <= '0;
            gnt_q        <= 2'b00;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_used_q[i] <= 1'b0;
                tag_vld_q[i]  <= 1'b0;
                tag_own_q[i]  <= 1'b0;
                tag_last_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            zlen_q       <= zlen_d;
            remaining_q  <= remaining_d;
            addr_q       <= addr_d;
            gnt_q        <= gnt_d;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_used_q[i] <= tag_used_q[i-1];
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_own_q[i]  <= tag_own_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
            // A zero-length burst still occupies a slot so that done emerges on time.
            tag_used_q[0] <= (state_q == BURST);
            tag_vld_q[0]  <= (state_q == BURST) && !zlen_q;
            tag_own_q[0]  <= owner_q;
            tag_last_q[0] <= final_cyc;
        end
    end

    always_comb begin
        gnt         = gnt_q;
        busy        = (state_q == BURST);
        mem_address = addr_q;
        rd_data     = mem_q;
        rd_valid    = 2'b00;
        done        = 2'b00;
        rd_last     = tag_vld_q[RD_LAT-1] && tag_last_q[RD_LAT-1];
        if (tag_vld_q[RD_LAT-1])
            rd_valid = tag_own_q[RD_LAT-1] ? 2'b10 : 2'b01;
        if (tag_used_q[RD_LAT-1] && tag_last_q[RD_LAT-1])
            done = tag_own_q[RD_LAT-1] ? 2'b10 : 2'b01;
    end

endmodule
